jtag_host: RTL and testbench
============================

# jtag_host

On-chip IEEE 1149.1 JTAG initiator that drives a TAP's TCK/TMS/TDI and captures TDO, the controller end of the voltmeter's TAP/test-interface chain. A simple valid/ready command port accepts RESET, SHIFT_IR, SHIFT_DR and IDLE operations. Each operation walks the TAP from Run-Test/Idle through the required state path and shifts up to 32 bits LSB-first. The block is used for self-test and loopback of the chip's TAP and by the bench as a reusable JTAG driver.

## Interface
- CLK_DIV, 2, clk_i cycles per TCK half-period (≥1)
- clk_i  in  1  system clock; everything, including tck_o, is generated in this domain
- rst_i  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  block idle, can accept a command
- cmd_op_i  in  2  00 RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE
- cmd_len_i  in  6  shift length (IR/DR) or TCK count (IDLE); valid range 1..32
- cmd_data_i  in  32  TDI data, bit 0 shifted first
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_err_o  out  1  qualifies rsp_valid_o; length out of range
- rsp_data_o  out  32  captured TDO, bit 0 = first captured; unused upper bits 0
- busy_o  out  1  equals ~cmd_ready_o
- tck_o  out  1  JTAG clock to TAP
- tms_o  out  1  JTAG mode select
- tdi_o  out  1  JTAG data to TAP
- tdo_i  in  1  JTAG data from TAP

## Operation
- Acceptance: a command is accepted at a clk edge where cmd_valid_i & cmd_ready_o. The op, len and data are latched. cmd_valid_i is ignored while busy.
- The home TAP state is Run-Test/Idle (RTI). Every command except RESET assumes RTI and ends in RTI.
- TMS sequences per TCK, in order:
  - RESET: 1,1,1,1,1,0 (6 TCK; ends in RTI). len and data are ignored.
  - SHIFT_IR: header 1,1,0,0; then len shift bits with TMS 0, except the last shift bit with TMS 1; then trailer 1,0. Total len+6 TCK.
  - SHIFT_DR: header 1,0,0; shift bits as for SHIFT_IR; trailer 1,0. Total len+5 TCK.
  - IDLE: len TCK with TMS 0.
- TDI and capture:
  - tdi_o = data[i] during shift bit i; 0 during all header, trailer and IDLE bits.
  - tdo_i is captured into rsp_data_o[i] only during shift bit i.
- Length error: for IR/DR/IDLE, cmd_len_i = 0 or > 32 produces no TCK edges. rsp_valid_o and rsp_err_o pulse in cycle 1, with rsp_data_o = 0. RESET never errors.
- State machine: IDLE → HDR → SHIFT → TRL → DONE → IDLE.
  - RESET and IDLE ops use HDR only.
  - Error goes IDLE → DONE directly.
- Between commands: tck_o = 0, tms_o holds its last value (0), tdi_o = 0.
- After rst_i the TAP state is unknown, so software must issue RESET first. The block does not track this.

## Timing
- Cycle 0 is the accept edge.
- Each TCK bit takes 2·CLK_DIV cycles:
  - tms_o/tdi_o update and tck_o goes 0 at the bit's first cycle, held CLK_DIV cycles.
  - tck_o = 1 for the next CLK_DIV cycles.
- tdo_i is sampled at the clk edge that drives tck_o 0→1, i.e. at TCK rise.
- N TCK bits occupy cycles 1..2·CLK_DIV·N.
- In cycle 2·CLK_DIV·N+1: tck_o = 0, rsp_valid_o = 1 (one cycle), rsp_data_o valid. rsp_data_o holds its value until the next response.
- cmd_ready_o is 0 from cycle 1 through the rsp cycle and returns to 1 in the following cycle. Maximum back-to-back rate is one accept every 2·CLK_DIV·N+2 cycles.
- There is no response backpressure.
- Reset values: cmd_ready_o 1, busy_o 0, rsp_valid_o 0, rsp_err_o 0, rsp_data_o 0, tck_o 0, tms_o 1, tdi_o 0.
- rst_i asserted mid-command: all outputs go to reset values immediately (asynchronously) and the in-flight command is dropped with no response.
- TCK high time and low time are both exactly CLK_DIV cycles. There are no glitches.

## Test plan
- RESET, CLK_DIV=2 → 6 TCK, TMS 1,1,1,1,1,0; rsp_valid_o at cycle 25; rsp_err_o=0; TAP model in RTI.
- SHIFT_IR len 4, data 0xA, model IR capture 0001 → TMS 1,1,0,0,0,0,0,1,1,0; TDI 0,1,0,1 in shift bits; model IR=1010; rsp_data_o=0x1; rsp at cycle 41.
- SHIFT_DR len 32, data 0xDEADBEEF, model in BYPASS (1-bit delay, captures 0) → 37 TCK, rsp_data_o=0xBD5B7DDE.
- SHIFT_DR len 0, then IDLE len 40 → each gives rsp_valid_o=rsp_err_o=1 in cycle 1, no tck_o edge, rsp_data_o=0.
- rst_i low during shift bit 10 of a DR len 32 → tck_o=0, tms_o=1, cmd_ready_o=1 immediately, no rsp. After release, RESET then IDLE len 3 complete normally.
- cmd_valid_i held high with two IDLE len 3 commands, CLK_DIV=1 → first rsp at cycle 7, second accepted at cycle 8, second rsp at cycle 15; cmd_valid_i during busy is not accepted.

Source files
------------

// File: rtl/jtag_host.sv
// IEEE 1149.1 JTAG initiator: walks the TAP from Run-Test/Idle through IR/DR scans,
// reset and idle clocking, shifting up to 32 bits LSB-first and capturing TDO.
module jtag_host #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [5:0]  cmd_len_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    output logic [31:0] rsp_data_o,
    output logic        busy_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i,
    output logic [2:0]  dbg_state_o
);

    // Handshake: a command transfers at a clk edge with cmd_valid_i & cmd_ready_o;
    // cmd_ready_o is high only in S_IDLE, so valid is ignored while busy. The
    // response is a single-cycle rsp_valid_o pulse with no backpressure.

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_SHIFT = 3'd2,
        S_TRL   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       idx_q, idx_d;
    logic [1:0]       op_q;
    logic [5:0]       len_q;
    logic [31:0]      data_q;
    logic [31:0]      cap_q;
    logic [31:0]      rsp_data_q;
    logic [DIV_W-1:0] div_q;
    logic             tck_q;
    logic             tms_q;
    logic             tdi_q;
    logic             err_q;

    logic accept;
    logic len_bad;
    logic active;
    logic half_end;
    logic bit_end;

    // Number of header TCKs; RESET and IDLE consist of header bits only.
    function automatic logic [5:0] hdr_len(input logic [1:0] op, input logic [5:0] len);
        logic [5:0] n;
        n = len;
        case (op)
            OP_RESET: n = 6'd6;
            OP_IR:    n = 6'd4;
            OP_DR:    n = 6'd3;
            default:  n = len;
        endcase
        return n;
    endfunction

    function automatic logic bit_tms(input state_t st, input logic [1:0] op,
                                     input logic [5:0] idx, input logic [5:0] len);
        logic t;
        t = 1'b0;
        case (st)
            S_HDR: begin
                case (op)
                    OP_RESET: t = (idx < 6'd5);
                    OP_IR:    t = (idx < 6'd2);
                    OP_DR:    t = (idx == 6'd0);
                    default:  t = 1'b0;
                endcase
            end
            S_SHIFT: t = (idx == len - 6'd1);
            S_TRL:   t = (idx == 6'd0);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign accept   = (state_q == S_IDLE) && cmd_valid_i;
    assign len_bad  = (cmd_op_i != OP_RESET) &&
                      ((cmd_len_i == 6'd0) || (cmd_len_i > 6'd32));
    assign active   = (state_q == S_HDR) || (state_q == S_SHIFT) || (state_q == S_TRL);
    assign half_end = active && (div_q == DIV_LAST);
    assign bit_end  = half_end && tck_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = len_bad ? S_DONE : S_HDR;
                    idx_d   = 6'd0;
                end
            end
            S_HDR: begin
                if (bit_end) begin
                    if (idx_q == hdr_len(op_q, len_q) - 6'd1) begin
                        idx_d   = 6'd0;
                        state_d = ((op_q == OP_IR) || (op_q == OP_DR)) ? S_SHIFT : S_DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_SHIFT: begin
                if (bit_end) begin
                    if (idx_q == len_q - 6'd1) begin
                        idx_d   = 6'd0;
                        state_d = S_TRL;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_TRL: begin
                if (bit_end) begin
                    if (idx_q == 6'd1) begin
                        idx_d   = 6'd0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // TMS/TDI change only at a bit boundary, together with TCK falling.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q       <= OP_RESET;
            len_q      <= 6'd0;
            data_q     <= 32'd0;
            cap_q      <= 32'd0;
            rsp_data_q <= 32'd0;
            div_q      <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept) begin
            op_q   <= cmd_op_i;
            len_q  <= cmd_len_i;
            data_q <= cmd_data_i;
            cap_q  <= 32'd0;
            div_q  <= '0;
            tck_q  <= 1'b0;
            tdi_q  <= 1'b0;
            if (len_bad) begin
                err_q      <= 1'b1;
                rsp_data_q <= 32'd0;
            end else begin
                err_q <= 1'b0;
                tms_q <= bit_tms(S_HDR, cmd_op_i, 6'd0, cmd_len_i);
            end
        end else if (active) begin
            if (half_end) begin
                div_q <= '0;
                if (!tck_q) begin
                    tck_q <= 1'b1;
                    if (state_q == S_SHIFT) begin
                        cap_q[idx_q[4:0]] <= tdo_i;
                    end
                end else begin
                    tck_q <= 1'b0;
                    if (state_d == S_DONE) begin
                        tdi_q      <= 1'b0;
                        rsp_data_q <= cap_q;
                    end else begin
                        tms_q <= bit_tms(state_d, op_q, idx_d, len_q);
                        tdi_q <= (state_d == S_SHIFT) ? data_q[idx_d[4:0]] : 1'b0;
                    end
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = ~cmd_ready_o;
    assign rsp_valid_o = (state_q == S_DONE);
    assign rsp_err_o   = err_q && (state_q == S_DONE);
    assign rsp_data_o  = rsp_data_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host: a 1149.1 TAP model answers the host, a response
// queue holds expected {err,data}, and TCK-sampled TMS/TDI are checked per command.
module tb_jtag_host;

    localparam int D = 2;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                   PDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11,
                   EX1IR = 12, PIR = 13, EX2IR = 14, UPIR = 15;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_ready, rsp_valid, rsp_err, busy, tck_o, tms_o, tdi_o, tdo;
    logic [31:0] rsp_data;
    logic [2:0]  dbg_state;

    logic        b_valid = 1'b0;
    logic [1:0]  b_op = 2'b00;
    logic [5:0]  b_len = 6'd0;
    logic [31:0] b_data = 32'd0;
    logic        b_ready, b_rsp_valid, b_rsp_err, b_busy, b_tck, b_tms, b_tdi;
    logic [31:0] b_rsp_data;
    logic [2:0]  b_dbg_state;

    jtag_host #(.CLK_DIV(D)) u_dut (
        .clk_i(clk), .rst_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_data_o(rsp_data),
        .busy_o(busy), .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo),
        .dbg_state_o(dbg_state)
    );

    jtag_host #(.CLK_DIV(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n),
        .cmd_valid_i(b_valid), .cmd_ready_o(b_ready),
        .cmd_op_i(b_op), .cmd_len_i(b_len), .cmd_data_i(b_data),
        .rsp_valid_o(b_rsp_valid), .rsp_err_o(b_rsp_err), .rsp_data_o(b_rsp_data),
        .busy_o(b_busy), .tck_o(b_tck), .tms_o(b_tms), .tdi_o(b_tdi), .tdo_i(1'b0),
        .dbg_state_o(b_dbg_state)
    );

    // TAP model: 4-bit IR capturing 0001, every DR is the 1-bit BYPASS register
    int         tap_st = TLR;
    logic [3:0] ir_sr = 4'd0;
    logic [3:0] ir = 4'd0;
    logic       byp = 1'b0;

    function automatic int tap_next(input int s, input logic t);
        case (s)
            TLR:     return t ? TLR   : RTI;
            RTI:     return t ? SELDR : RTI;
            SELDR:   return t ? SELIR : CAPDR;
            CAPDR:   return t ? EX1DR : SHDR;
            SHDR:    return t ? EX1DR : SHDR;
            EX1DR:   return t ? UPDR  : PDR;
            PDR:     return t ? EX2DR : PDR;
            EX2DR:   return t ? UPDR  : SHDR;
            UPDR:    return t ? SELDR : RTI;
            SELIR:   return t ? TLR   : CAPIR;
            CAPIR:   return t ? EX1IR : SHIR;
            SHIR:    return t ? EX1IR : SHIR;
            EX1IR:   return t ? UPIR  : PIR;
            PIR:     return t ? EX2IR : PIR;
            EX2IR:   return t ? UPIR  : SHIR;
            UPIR:    return t ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck_o) begin
        case (tap_st)
            CAPIR:   ir_sr <= 4'b0001;
            SHIR:    ir_sr <= {tdi_o, ir_sr[3:1]};
            UPIR:    ir    <= ir_sr;
            CAPDR:   byp   <= 1'b0;
            SHDR:    byp   <= tdi_o;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms_o);
    end

    assign tdo = (tap_st == SHIR) ? ir_sr[0] : ((tap_st == SHDR) ? byp : 1'b0);

    // Pin monitor
    logic tms_log[$];
    logic tdi_log[$];
    int   hi_cycles = 0;

    always @(posedge tck_o) begin
        tms_log.push_back(tms_o);
        tdi_log.push_back(tdi_o);
    end

    always @(posedge clk) begin
        if (tck_o) hi_cycles <= hi_cycles + 1;
    end

    // Scoreboard
    logic [32:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [5:0] len,
                          input logic [31:0] data, input logic exp_err,
                          input logic [31:0] exp_data, input int exp_cyc, input int exp_ntck,
                          input logic [63:0] exp_tms, input logic [63:0] exp_tdi);
        int          cyc;
        int          wait_n;
        int          start_n;
        int          start_hi;
        int          n;
        logic [63:0] tms_v;
        logic [63:0] tdi_v;
        logic [32:0] exp_rsp;
        wait_n = 0;
        @(negedge clk);
        while (!cmd_ready && wait_n < 300) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        start_n  = tms_log.size();
        start_hi = hi_cycles;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        exp_q.push_back({exp_err, exp_data});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 400);
        check({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
        check({tag, "_rsp_cycle"}, 64'(cyc), 64'(exp_cyc));
        exp_rsp = exp_q.pop_front();
        check({tag, "_rsp"}, 64'({rsp_err, rsp_data}), 64'(exp_rsp));
        n = tms_log.size() - start_n;
        check({tag, "_tck_count"}, 64'(n), 64'(exp_ntck));
        tms_v = 64'd0;
        tdi_v = 64'd0;
        for (int k = 0; k < n && k < 64; k++) begin
            tms_v[k] = tms_log[start_n + k];
            tdi_v[k] = tdi_log[start_n + k];
        end
        check({tag, "_tms_seq"}, tms_v, exp_tms);
        check({tag, "_tdi_seq"}, tdi_v, exp_tdi);
        check({tag, "_tck_high"}, 64'(hi_cycles - start_hi), 64'(D * exp_ntck));
        @(negedge clk);
        check({tag, "_after"}, 64'({cmd_ready, busy, rsp_valid, tck_o, tms_o, tdi_o}),
              64'(6'b100000));
        check({tag, "_data_held"}, 64'(rsp_data), 64'(exp_data));
    endtask

    // Directed sequence
    initial begin
        int          seen;
        int          lens[3];
        int          acc_cyc;
        int          acc_seen;
        int          rsp_n;
        int          rsp_cyc[4];
        logic [31:0] d;
        logic [63:0] m;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
        check("rst_data", 64'(rsp_data), 64'd0);
        check("rst_pins", 64'({tck_o, tms_o, tdi_o}), 64'(3'b010));
        rst_n = 1'b1;

        do_cmd("reset", 2'b00, 6'd0, 32'd0, 1'b0, 32'd0, 25, 6, 64'h1F, 64'h0);
        check("reset_tap_rti", 64'(tap_st), 64'(RTI));

        do_cmd("ir4", 2'b01, 6'd4, 32'hA, 1'b0, 32'h1, 41, 10, 64'h183, 64'hA0);
        check("ir4_model_ir", 64'(ir), 64'(4'b1010));
        check("ir4_tap_rti", 64'(tap_st), 64'(RTI));

        do_cmd("dr32", 2'b10, 6'd32, 32'hDEADBEEF, 1'b0, 32'hBD5B7DDE, 149, 37,
               64'h0000_000C_0000_0001, 64'h6_F56D_F778);
        check("dr32_tap_rti", 64'(tap_st), 64'(RTI));

        lens[0] = 1;
        lens[1] = $urandom_range(2, 31);
        lens[2] = $urandom_range(2, 31);
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            m = (64'd1 << lens[i]) - 64'd1;
            do_cmd("dr_rand", 2'b10, 6'(lens[i]), d, 1'b0, 32'(({32'd0, d} << 1) & m),
                   4 * (lens[i] + 5) + 1, lens[i] + 5,
                   64'd1 | (64'd1 << (lens[i] + 2)) | (64'd1 << (lens[i] + 3)),
                   ({32'd0, d} & m) << 3);
        end

        lens[0] = 1;
        lens[1] = 32;
        lens[2] = $urandom_range(2, 31);
        for (int i = 0; i < 3; i++) begin
            do_cmd("idle", 2'b11, 6'(lens[i]), $urandom, 1'b0, 32'd0,
                   4 * lens[i] + 1, lens[i], 64'h0, 64'h0);
        end

        do_cmd("err_dr0", 2'b10, 6'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 1, 0, 64'h0, 64'h0);
        do_cmd("err_idle40", 2'b11, 6'd40, 32'd0, 1'b1, 32'd0, 1, 0, 64'h0, 64'h0);
        do_cmd("err_ir33", 2'b01, 6'd33, 32'd5, 1'b1, 32'd0, 1, 0, 64'h0, 64'h0);

        // Reset in shift bit 10 of a 32-bit DR scan (TCK bit 13, high phase)
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_len   = 6'd32;
        cmd_data  = $urandom;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (55) @(negedge clk);
        check("mid_tck_high", 64'(tck_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pins", 64'({cmd_ready, busy, rsp_valid, rsp_err, tck_o, tms_o, tdi_o}),
              64'(7'b1000010));
        check("mid_rst_data", 64'(rsp_data), 64'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mid_no_rsp", 64'(seen), 64'd0);
        do_cmd("post_reset", 2'b00, 6'd0, 32'd0, 1'b0, 32'd0, 25, 6, 64'h1F, 64'h0);
        check("post_reset_tap_rti", 64'(tap_st), 64'(RTI));
        do_cmd("post_idle3", 2'b11, 6'd3, 32'd0, 1'b0, 32'd0, 13, 3, 64'h0, 64'h0);

        // Back-to-back IDLE len 3 with valid held high, CLK_DIV = 1
        exp_q.push_back(33'd0);
        exp_q.push_back(33'd0);
        acc_cyc  = -1;
        acc_seen = 0;
        rsp_n    = 0;
        for (int i = 0; i < 4; i++) rsp_cyc[i] = -1;
        @(negedge clk);
        b_valid = 1'b1;
        b_op    = 2'b11;
        b_len   = 6'd3;
        @(posedge clk);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (acc_seen != 0) b_valid = 1'b0;
            if (b_rsp_valid) begin
                if (rsp_n < 4) rsp_cyc[rsp_n] = cyc;
                rsp_n++;
                if (exp_q.size() > 0)
                    check("b2b_rsp", 64'({b_rsp_err, b_rsp_data}), 64'(exp_q.pop_front()));
            end
            if (b_valid && b_ready) begin
                acc_cyc  = cyc;
                acc_seen = 1;
            end
        end
        b_valid = 1'b0;
        check("b2b_rsp_count", 64'(rsp_n), 64'd2);
        check("b2b_rsp1_cycle", 64'(rsp_cyc[0]), 64'd7);
        check("b2b_accept2_cycle", 64'(acc_cyc), 64'd8);
        check("b2b_rsp2_cycle", 64'(rsp_cyc[1]), 64'd15);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
